// File: rtl/sdhci_cmd_pkg.sv
// sdhci_cmd_pkg
// Shared types and constants for the SD command-line transmit path.
// Contents:
//   cmd_tx_state_e : state encoding of the command serialiser
//   CmdHeaderBits  : start + transmission + index + argument bits (40)
//   Crc7Bits       : width of the command CRC (7)
//   CmdFrameBits   : complete frame length including CRC and end bit (48)
//   Crc7Poly       : CRC7 generator polynomial x^7 + x^3 + 1 without the x^7 term
//   buildHeader()  : packs index and argument behind the start/transmission bits
package sdhci_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHIFT_CMD  = 3'd1,
    SHIFT_CRC  = 3'd2,
    END_BIT    = 3'd3,
    TURNAROUND = 3'd4,
    NCC_WAIT   = 3'd5
  } cmd_tx_state_e;

  localparam int CmdHeaderBits = 40;
  localparam int Crc7Bits      = 7;
  localparam int CmdFrameBits  = 48;

  localparam logic [Crc7Bits-1:0] Crc7Poly = 7'h09;

  // Start bit is 0 and the transmission bit is 1 (host to card).
  function automatic logic [CmdHeaderBits-1:0] buildHeader(
    input logic [5:0]  index,
    input logic [31:0] arg
  );
    return {2'b01, index, arg};
  endfunction

endpackage

// File: rtl/crc7_write.sv
// crc7_write
// Serial CRC7 generator for the transmit side. Bits are folded in one per
// clock while enable_i is high; afterwards the remainder can be walked out
// MSB first by asserting shift_i, which moves the register left and fills
// with zeros so the next CRC bit to send is always at crc7_o[6].
// Ports:
//   sd_clk_i  : clock, rising edge
//   rst_i     : asynchronous active-high reset, clears the remainder
//   clear_i   : synchronous clear, highest priority
//   enable_i  : fold data_i into the remainder this cycle
//   data_i    : serial data bit being transmitted
//   shift_i   : shift the remainder out (takes priority over enable_i)
//   crc7_o    : current remainder
module crc7_write
  import sdhci_cmd_pkg::*;
(
  input  logic                sd_clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic                data_i,
  input  logic                shift_i,
  output logic [Crc7Bits-1:0] crc7_o
);

  logic [Crc7Bits-1:0] r_crc;
  logic                w_feedback;

  assign w_feedback = data_i ^ r_crc[Crc7Bits-1];
  assign crc7_o     = r_crc;

  // Linear feedback shift register with the polynomial taps applied whenever
  // the outgoing MSB differs from the incoming data bit.
  always_ff @(posedge sd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_crc <= '0;
    end else if (clear_i) begin
      r_crc <= '0;
    end else if (shift_i) begin
      r_crc <= {r_crc[Crc7Bits-2:0], 1'b0};
    end else if (enable_i) begin
      r_crc <= {r_crc[Crc7Bits-2:0], 1'b0} ^ (w_feedback ? Crc7Poly : '0);
    end
  end

endmodule

// File: rtl/cmd_write.sv
// cmd_write
// Serialises one SD command frame onto the CMD line, MSB first:
//   start(0), transmission(1), index[5:0], arg[31:0], crc7[6:0], end(1).
// All outputs are registered. The start bit is on cmd_o in the first cycle
// after accept, the end bit 48 cycles after accept, start_listening_o two
// cycles after the end bit and done_o 50 cycles after accept.
// Optional build macro CMD_WRITE_NCC_EN: after the turnaround the line is
// held released for NccCycles further cycles before IDLE, and done_o moves
// to the last of those cycles.
// Ports:
//   sd_clk_i          : SD clock, rising edge
//   rst_i             : asynchronous active-high reset
//   start_tx_i        : send request, only looked at in IDLE
//   cmd_index_i       : command index, latched on accept
//   cmd_arg_i         : command argument, latched on accept
//   rsp_expected_i    : a response follows this command, latched on accept
//   cmd_o             : serial CMD bit (1 when not transmitting)
//   cmd_en_o          : CMD pad output enable
//   busy_o            : high from accept until back in IDLE
//   done_o            : one-cycle pulse in the last busy cycle
//   start_listening_o : one-cycle pulse arming the response receiver
module cmd_write
  import sdhci_cmd_pkg::*;
#(
  parameter int NccCycles = 8
) (
  input  logic        sd_clk_i,
  input  logic        rst_i,
  input  logic        start_tx_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  input  logic        rsp_expected_i,
  output logic        cmd_o,
  output logic        cmd_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        start_listening_o
);

  // The counter walks header bits 0..39; it only needs to grow when a very
  // long NCC gap is configured.
  localparam int CntW    = (NccCycles > 63) ? $clog2(NccCycles + 1) : 6;
  localparam int HdrLast = CmdHeaderBits - 1;

  localparam logic [CntW-1:0] CntHdrLast = CntW'(CmdHeaderBits - 1);
  localparam logic [CntW-1:0] CntCrcLast = CntW'(CmdFrameBits - CmdHeaderBits - 2);
`ifdef CMD_WRITE_NCC_EN
  localparam logic [CntW-1:0] CntNccLast = CntW'(NccCycles - 1);
`endif

  cmd_tx_state_e          r_state;
  logic [CntW-1:0]        r_cnt;
  logic [HdrLast:0]       r_hdr;
  logic                   r_rsp;
  logic                   r_cmd;
  logic                   r_cmdEn;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_listen;

  logic [HdrLast:0]       w_newHdr;
  logic                   w_accept;
  logic                   w_crcClear;
  logic                   w_crcEnable;
  logic                   w_crcData;
  logic                   w_crcShift;
  logic [Crc7Bits-1:0]    w_crc;

  assign w_newHdr = buildHeader(cmd_index_i, cmd_arg_i);
  assign w_accept = (r_state == IDLE) && start_tx_i;

  assign cmd_o             = r_cmd;
  assign cmd_en_o          = r_cmdEn;
  assign busy_o            = r_busy;
  assign done_o            = r_done;
  assign start_listening_o = r_listen;

  // The CRC absorbs each header bit at the same edge that loads it into the
  // cmd_o register, so the remainder is complete by the time the last header
  // bit is on the line and the first CRC bit must be loaded. The remainder is
  // cleared during the end bit, ready for the next command.
  always_comb begin
    w_crcClear  = (r_state == END_BIT);
    w_crcEnable = w_accept || ((r_state == SHIFT_CMD) && (r_cnt != CntHdrLast));
    w_crcData   = (r_state == IDLE) ? w_newHdr[HdrLast] : r_hdr[HdrLast];
    w_crcShift  = ((r_state == SHIFT_CMD) && (r_cnt == CntHdrLast)) ||
                  ((r_state == SHIFT_CRC) && (r_cnt != CntCrcLast));
  end

  crc7_write u_crc7 (
    .sd_clk_i (sd_clk_i),
    .rst_i    (rst_i),
    .clear_i  (w_crcClear),
    .enable_i (w_crcEnable),
    .data_i   (w_crcData),
    .shift_i  (w_crcShift),
    .crc7_o   (w_crc)
  );

  // Main sequencer. r_state and r_cnt describe what is on the line in the
  // current cycle; each branch loads the outputs for the following cycle.
  // r_hdr always holds the next header bit to send in its MSB.
  always_ff @(posedge sd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_hdr    <= '0;
      r_rsp    <= 1'b0;
      r_cmd    <= 1'b1;
      r_cmdEn  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_listen <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done   <= 1'b0;
          r_listen <= 1'b0;
          if (start_tx_i) begin
            r_state <= SHIFT_CMD;
            r_cnt   <= '0;
            r_hdr   <= {w_newHdr[HdrLast-1:0], 1'b0};
            r_rsp   <= rsp_expected_i;
            r_cmd   <= w_newHdr[HdrLast];
            r_cmdEn <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_cmd   <= 1'b1;
            r_cmdEn <= 1'b0;
            r_busy  <= 1'b0;
          end
        end

        SHIFT_CMD: begin
          if (r_cnt == CntHdrLast) begin
            r_state <= SHIFT_CRC;
            r_cnt   <= '0;
            r_cmd   <= w_crc[Crc7Bits-1];
          end else begin
            r_cnt   <= r_cnt + CntW'(1);
            r_cmd   <= r_hdr[HdrLast];
            r_hdr   <= {r_hdr[HdrLast-1:0], 1'b0};
          end
        end

        SHIFT_CRC: begin
          if (r_cnt == CntCrcLast) begin
            r_state <= END_BIT;
            r_cmd   <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CntW'(1);
            r_cmd   <= w_crc[Crc7Bits-1];
          end
        end

        END_BIT: begin
          r_state <= TURNAROUND;
          r_cnt   <= '0;
          r_cmd   <= 1'b1;
          r_cmdEn <= 1'b0;
        end

        TURNAROUND: begin
          if (r_cnt == '0) begin
            r_cnt    <= CntW'(1);
            r_listen <= r_rsp;
`ifndef CMD_WRITE_NCC_EN
            r_done   <= 1'b1;
`endif
          end else begin
            r_listen <= 1'b0;
            r_cnt    <= '0;
`ifdef CMD_WRITE_NCC_EN
            r_state  <= NCC_WAIT;
            r_done   <= (NccCycles == 1);
`else
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`endif
          end
        end

`ifdef CMD_WRITE_NCC_EN
        NCC_WAIT: begin
          if (r_cnt == CntNccLast) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + CntW'(1);
            r_done  <= ((r_cnt + CntW'(1)) == CntNccLast);
          end
        end
`endif

        default: begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_hdr    <= '0;
          r_rsp    <= 1'b0;
          r_cmd    <= 1'b1;
          r_cmdEn  <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_listen <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_write.sv
// tb_cmd_write
// Bench for cmd_write. Known SD frames from a vector table, then random
// commands checked against a CRC7 reference computed by polynomial long
// division, plus hand-written sequences for a held start request with
// changing inputs and an asynchronous reset in the middle of a frame.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cmd_write;

  logic        sd_clk_i = 1'b0;
  logic        rst_i;
  logic        start_tx_i;
  logic [5:0]  cmd_index_i;
  logic [31:0] cmd_arg_i;
  logic        rsp_expected_i;
  logic        cmd_o;
  logic        cmd_en_o;
  logic        busy_o;
  logic        done_o;
  logic        start_listening_o;

  int errors = 0;
  int checks = 0;

  localparam int EndBitCycle = 48;
  localparam int ListenCycle = 50;
`ifdef CMD_WRITE_NCC_EN
  localparam int DoneCycle   = 58;
`else
  localparam int DoneCycle   = 50;
`endif

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    bit          rsp;
    logic [47:0] frame;
  } vec_t;

  vec_t vecs [6];

  cmd_write #(.NccCycles(8)) dut (
    .sd_clk_i          (sd_clk_i),
    .rst_i             (rst_i),
    .start_tx_i        (start_tx_i),
    .cmd_index_i       (cmd_index_i),
    .cmd_arg_i         (cmd_arg_i),
    .rsp_expected_i    (rsp_expected_i),
    .cmd_o             (cmd_o),
    .cmd_en_o          (cmd_en_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .start_listening_o (start_listening_o)
  );

  always #5 sd_clk_i = ~sd_clk_i;

  // Remainder of header(x) * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] modelCrc(input logic [39:0] hdr);
    logic [46:0] r;
    r = {hdr, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] modelFrame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] hdr;
    hdr = {2'b01, idx, arg};
    return {hdr, modelCrc(hdr), 1'b1};
  endfunction

  // Single comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a command for one accept edge, then drop the request.
  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input bit rsp);
    @(negedge sd_clk_i);
    cmd_index_i    = idx;
    cmd_arg_i      = arg;
    rsp_expected_i = rsp;
    start_tx_i     = 1'b1;
    @(negedge sd_clk_i);
    start_tx_i     = 1'b0;
  endtask

  task automatic scrambleData();
    cmd_index_i    = 6'($urandom);
    cmd_arg_i      = $urandom;
    rsp_expected_i = 1'($urandom);
  endtask

  // Called at the falling edge of cycle 1 after accept. Records every output
  // up to the first idle cycle and compares against the frame timeline.
  // mode 0: inputs left alone; 1: data and start_tx_i randomised while busy;
  // 2: data randomised with start_tx_i left as the caller set it.
  task automatic checkFrame(input logic [47:0] expFrame, input bit rsp,
                            input int mode, input string name);
    logic [47:0] frame;
    logic [63:0] en, busy, done, listen, lowReleased;
    logic [63:0] enExp, busyExp, doneExp, listenExp;
    frame = '0;
    en = '0; busy = '0; done = '0; listen = '0; lowReleased = '0;
    enExp = '0; busyExp = '0; doneExp = '0; listenExp = '0;
    for (int n = 1; n <= DoneCycle + 1; n++) begin
      if (n <= EndBitCycle) frame = {frame[46:0], cmd_o};
      en[n]          = cmd_en_o;
      busy[n]        = busy_o;
      done[n]        = done_o;
      listen[n]      = start_listening_o;
      lowReleased[n] = !cmd_en_o && !cmd_o;
      enExp[n]       = (n <= EndBitCycle);
      busyExp[n]     = (n <= DoneCycle);
      doneExp[n]     = (n == DoneCycle);
      listenExp[n]   = rsp && (n == ListenCycle);
      if (n <= DoneCycle) begin
        if (mode != 0) scrambleData();
        if (mode == 1) start_tx_i = (n == DoneCycle) ? 1'b0 : 1'($urandom);
        @(negedge sd_clk_i);
      end
    end
    checkOutput($sformatf("%s.frame", name), 64'(frame), 64'(expFrame));
    checkOutput($sformatf("%s.cmd_en", name), en, enExp);
    checkOutput($sformatf("%s.busy", name), busy, busyExp);
    checkOutput($sformatf("%s.done", name), done, doneExp);
    checkOutput($sformatf("%s.listen", name), listen, listenExp);
    checkOutput($sformatf("%s.released_low", name), lowReleased, 64'd0);
  endtask

  initial begin
    rst_i          = 1'b1;
    start_tx_i     = 1'b0;
    cmd_index_i    = '0;
    cmd_arg_i      = '0;
    rsp_expected_i = 1'b0;

    vecs[0] = '{6'd0,  32'h0000_0000, 1'b0, 48'h40_0000_0000_95};
    vecs[1] = '{6'd8,  32'h0000_01AA, 1'b1, 48'h48_0000_01AA_87};
    vecs[2] = '{6'd17, 32'h0000_0000, 1'b0, 48'h51_0000_0000_55};
    vecs[3] = '{6'd55, 32'h0000_0000, 1'b1, modelFrame(6'd55, 32'h0000_0000)};
    vecs[4] = '{6'd41, 32'h40FF_8000, 1'b1, modelFrame(6'd41, 32'h40FF_8000)};
    vecs[5] = '{6'h3F, 32'hFFFF_FFFF, 1'b1, modelFrame(6'h3F, 32'hFFFF_FFFF)};

    // Reset values while held in reset.
    repeat (2) @(negedge sd_clk_i);
    checkOutput("reset.cmd", 64'(cmd_o), 64'd1);
    checkOutput("reset.cmd_en", 64'(cmd_en_o), 64'd0);
    checkOutput("reset.busy", 64'(busy_o), 64'd0);
    checkOutput("reset.done", 64'(done_o), 64'd0);
    checkOutput("reset.listen", 64'(start_listening_o), 64'd0);
    rst_i = 1'b0;
    @(negedge sd_clk_i);
    checkOutput("postreset.busy", 64'(busy_o), 64'd0);

    // Table-driven known frames; odd entries also disturb inputs while busy.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].idx, vecs[i].arg, vecs[i].rsp);
      checkFrame(vecs[i].frame, vecs[i].rsp, i % 2, $sformatf("vec%0d", i));
    end

    // Random commands against the reference model.
    for (int i = 0; i < 8; i++) begin
      logic [5:0]  rIdx;
      logic [31:0] rArg;
      bit          rRsp;
      rIdx = 6'($urandom);
      rArg = $urandom;
      rRsp = 1'($urandom);
      applyStimulus(rIdx, rArg, rRsp);
      checkFrame(modelFrame(rIdx, rArg), rRsp, 1, $sformatf("rand%0d", i));
    end

    // start_tx_i held high throughout: the second command is only taken
    // from the idle cycle after done_o.
    @(negedge sd_clk_i);
    cmd_index_i    = 6'd8;
    cmd_arg_i      = 32'h0000_01AA;
    rsp_expected_i = 1'b1;
    start_tx_i     = 1'b1;
    @(negedge sd_clk_i);
    checkFrame(48'h48_0000_01AA_87, 1'b1, 2, "held1");
    cmd_index_i    = 6'd17;
    cmd_arg_i      = 32'h0000_0000;
    rsp_expected_i = 1'b0;
    @(negedge sd_clk_i);
    start_tx_i     = 1'b0;
    checkFrame(48'h51_0000_0000_55, 1'b0, 0, "held2");

    // Asynchronous reset while header bit 20 is on the line.
    applyStimulus(6'd17, 32'h1234_5678, 1'b1);
    repeat (20) @(negedge sd_clk_i);
    checkOutput("midrst.pre_en", 64'(cmd_en_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("midrst.cmd_en", 64'(cmd_en_o), 64'd0);
    checkOutput("midrst.cmd", 64'(cmd_o), 64'd1);
    checkOutput("midrst.busy", 64'(busy_o), 64'd0);
    @(negedge sd_clk_i);
    rst_i = 1'b0;
    @(negedge sd_clk_i);
    checkOutput("midrst.after_busy", 64'(busy_o), 64'd0);
    checkOutput("midrst.after_en", 64'(cmd_en_o), 64'd0);
    applyStimulus(6'd0, 32'h0000_0000, 1'b0);
    checkFrame(48'h40_0000_0000_95, 1'b0, 0, "aftrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
